// File: rtl/trace_pkg.sv
// trace_pkg: state/mode encodings and record sizing shared by the commit-trace buffer
package trace_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam logic [1:0] MODE_FILL = 2'd0;
    localparam logic [1:0] MODE_RING = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;
    function automatic int rec_w(input int data_w, input int ridx_w);
        return 2 * data_w + 1 + ridx_w + data_w;
    endfunction
endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: DEPTH-entry ring of records; level counter keeps full and empty distinct
module trace_ring_mem
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   wdata,
    output logic [W-1:0]   rdata,
    output logic [PTR_W:0] level,
    output logic           full,
    output logic           empty
);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    assign full  = level == DEPTH_L;
    assign empty = level == '0;
    // head field reads as zero while nothing is stored
    assign rdata = empty ? '0 : mem[head];
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (push && !pop) level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end
    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= wdata;
    end
endmodule

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: commit-trace recorder with fill, ring and PC-trigger capture modes
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RIDX_W = 5,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int DROP_W = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [PTR_W:0]    post_cnt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic              in_we,
    input  logic [RIDX_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_we,
    output logic [RIDX_W-1:0] out_waddr,
    output logic [DATA_W-1:0] out_wdata,
    output logic [PTR_W:0]    level,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [1:0]        state,
    output logic              triggered
);
    localparam int REC_W = rec_w(DATA_W, RIDX_W);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);
    state_t            st, st_n;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] trig_q;
    logic [PTR_W:0]    post_q, rem;
    logic [REC_W-1:0]  rdata;
    logic full, empty, accept, pop_req, push, mem_pop, trig_hit, post_last, lost;
    assign accept    = in_valid && (st == ST_ARMED || st == ST_POST) && !arm && !stop;
    assign pop_req   = out_valid && out_ready && !arm;
    assign lost      = accept && full && !pop_req;
    // a full ring with no consumer pop makes room by retiring the oldest entry
    assign push      = accept && (!full || pop_req || mode_q != MODE_FILL);
    assign mem_pop   = pop_req || (lost && mode_q != MODE_FILL);
    assign trig_hit  = accept && st == ST_ARMED && mode_q == MODE_TRIG && in_pc == trig_q;
    assign post_last = accept && st == ST_POST && rem == (PTR_W + 1)'(1);
    assign out_valid = !empty;
    assign state     = st;
    assign {out_pc, out_inst, out_we, out_waddr, out_wdata} = rdata;
    trace_ring_mem #(.DEPTH(DEPTH), .W(REC_W), .PTR_W(PTR_W)) u_mem (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (arm),
        .push   (push),
        .pop    (mem_pop),
        .wdata  ({in_pc, in_inst, in_we, in_waddr, in_wdata}),
        .rdata  (rdata),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) st <= ST_IDLE;
        else st <= st_n;
    end
    always_comb begin
        st_n = st;
        if (arm) st_n = ST_ARMED;
        else if (stop && (st == ST_ARMED || st == ST_POST)) st_n = ST_DONE;
        else if (trig_hit) st_n = post_q == '0 ? ST_DONE : ST_POST;
        else if (post_last) st_n = ST_DONE;
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_FILL;
            trig_q    <= '0;
            post_q    <= '0;
            rem       <= '0;
            drop_cnt  <= '0;
            triggered <= 1'b0;
        end else if (arm) begin
            mode_q    <= (mode == MODE_RING || mode == MODE_TRIG) ? mode : MODE_FILL;
            trig_q    <= trig_pc;
            post_q    <= post_cnt > DEPTH_L ? DEPTH_L : post_cnt;
            rem       <= '0;
            drop_cnt  <= '0;
            triggered <= 1'b0;
        end else begin
            if (lost && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            if (trig_hit) begin
                triggered <= 1'b1;
                rem       <= post_q;
            end else if (accept && st == ST_POST) begin
                rem <= rem - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: directed scenarios plus random traffic against a queue-based model
module tb_trace_capture_buffer;
    localparam int DEPTH = 8;
    logic        clk_in = 1'b0, reset = 1'b1, arm = 1'b0, stop = 1'b0;
    logic        in_valid = 1'b0, in_we = 1'b0, out_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] trig_pc = '0, in_pc = '0, in_inst = '0, in_wdata = '0;
    logic [3:0]  post_cnt = '0;
    logic [4:0]  in_waddr = '0;
    logic        out_valid, out_we, triggered;
    logic [31:0] out_pc, out_inst, out_wdata;
    logic [4:0]  out_waddr;
    logic [3:0]  level;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    trace_capture_buffer dut (
        .clk_in(clk_in), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
        .trig_pc(trig_pc), .post_cnt(post_cnt), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata), .level(level),
        .drop_cnt(drop_cnt), .state(state), .triggered(triggered)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    rec_t        q[$];
    int          m_st = 0, m_drop = 0, m_rem = 0, m_post = 0, m_mode = 0;
    bit          m_trig = 0;
    logic [31:0] m_tpc = '0;
    int          errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        rec_t h = '{default: '0};
        if (q.size() != 0) h = q[0];
        check("level", 64'(level), 64'(q.size()));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("out_pc", 64'(out_pc), 64'(h.pc));
        check("out_inst", 64'(out_inst), 64'(h.inst));
        check("out_we", 64'(out_we), 64'(h.we));
        check("out_waddr", 64'(out_waddr), 64'(h.waddr));
        check("out_wdata", 64'(out_wdata), 64'(h.wdata));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("state", 64'(state), 64'(m_st));
        check("triggered", 64'(triggered), 64'(m_trig));
    endtask

    // advance the model by one clock using the inputs presented now, then clock the DUT
    task automatic tick();
        int   st0 = m_st;
        bit   acc, pop;
        rec_t cur;
        cur = '{in_pc, in_inst, in_we, in_waddr, in_wdata};
        pop = out_ready && q.size() != 0 && !arm;
        acc = in_valid && (st0 == 1 || st0 == 2) && !arm && !stop;
        if (arm) begin
            q.delete();
            m_drop = 0;
            m_trig = 0;
            m_mode = (mode == 2'd1 || mode == 2'd2) ? int'(mode) : 0;
            m_tpc  = trig_pc;
            m_post = (post_cnt > DEPTH) ? DEPTH : int'(post_cnt);
            m_st   = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (q.size() == DEPTH) begin
                    if (m_drop < 65535) m_drop++;
                    if (m_mode != 0) begin
                        void'(q.pop_front());
                        q.push_back(cur);
                    end
                end else begin
                    q.push_back(cur);
                end
                if (st0 == 1 && m_mode == 2 && in_pc == m_tpc) begin
                    m_trig = 1;
                    m_rem  = m_post;
                    m_st   = (m_post == 0) ? 3 : 2;
                end else if (st0 == 2) begin
                    m_rem--;
                    if (m_rem == 0) m_st = 3;
                end
            end
            if (stop && (st0 == 1 || st0 == 2)) m_st = 3;
        end
        @(posedge clk_in);
        #1;
        compare();
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = pc ^ 32'h1357_9bdf;
        in_we    = pc[2];
        in_waddr = pc[6:2];
        in_wdata = ~pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] md, input logic [31:0] tp, input logic [3:0] pcnt);
        arm      = 1'b1;
        mode     = md;
        trig_pc  = tp;
        post_cnt = pcnt;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain_expect(input string tag, input logic [31:0] first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(tag, 64'(out_pc), 64'(first + 32'(4 * i)));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 64'(level), 64'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_st   = 0;
        m_drop = 0;
        m_trig = 0;
        m_rem  = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        model_reset();
        compare();
        check("rst_state", 64'(state), 64'd0);

        // asynchronous reset in the middle of a capture
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 3; i++) push(32'h0040_0000 + 32'(4 * i));
        check("pre_rst_level", 64'(level), 64'd3);
        #3;
        reset = 1'b1;
        #1;
        check("arst_level", 64'(level), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_state", 64'(state), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        compare();
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        compare();

        // FILL: overflow is discarded and counted
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 10; i++) push(32'h0040_0000 + 32'(4 * i));
        check("fill_level", 64'(level), 64'd8);
        check("fill_drop", 64'(drop_cnt), 64'd2);
        check("fill_state", 64'(state), 64'd1);
        drain_expect("fill_pc", 32'h0040_0000, 8);

        // RING: overflow retires the oldest entries
        do_arm(2'd1, '0, '0);
        for (int i = 0; i < 10; i++) push(32'h0040_0000 + 32'(4 * i));
        check("ring_level", 64'(level), 64'd8);
        check("ring_drop", 64'(drop_cnt), 64'd2);
        drain_expect("ring_pc", 32'h0040_0008, 8);

        // TRIG: two records kept after the trigger address
        do_arm(2'd2, 32'h0040_0014, 4'd2);
        for (int i = 0; i < 10; i++) begin
            push(32'h0040_0000 + 32'(4 * i));
            if (i == 4) check("trig_before", 64'(triggered), 64'd0);
            if (i == 5) check("trig_flag", 64'(triggered), 64'd1);
            if (i == 6) check("trig_post", 64'(state), 64'd2);
            if (i == 7) check("trig_done", 64'(state), 64'd3);
        end
        check("trig_level", 64'(level), 64'd8);
        check("trig_drop", 64'(drop_cnt), 64'd0);
        drain_expect("trig_pc", 32'h0040_0000, 8);

        // RING at full with continuous consumer pops
        do_arm(2'd1, '0, '0);
        for (int i = 0; i < 8; i++) push(32'h0040_0000 + 32'(4 * i));
        out_ready = 1'b1;
        for (int i = 8; i < 28; i++) begin
            push(32'h0040_0000 + 32'(4 * i));
            check("pp_level", 64'(level), 64'd8);
            check("pp_drop", 64'(drop_cnt), 64'd0);
            check("pp_head", 64'(out_pc), 64'(32'h0040_0000 + 32'(4 * (i - 7))));
        end
        out_ready = 1'b0;

        // stop, then re-arm in RING with a record on the arm cycle
        do_arm(2'd0, '0, '0);
        for (int i = 0; i < 3; i++) push(32'h0050_0000 + 32'(4 * i));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_state", 64'(state), 64'd3);
        push(32'h0050_0100);
        check("stop_ignore", 64'(level), 64'd3);
        in_valid = 1'b1;
        in_pc    = 32'h0060_0000;
        do_arm(2'd1, '0, '0);
        in_valid = 1'b0;
        check("rearm_level", 64'(level), 64'd0);
        check("rearm_state", 64'(state), 64'd1);
        for (int i = 0; i < 9; i++) push(32'h0070_0000 + 32'(4 * i));
        check("rearm_drop", 64'(drop_cnt), 64'd1);
        drain_expect("rearm_pc", 32'h0070_0004, 8);

        // random traffic over a small PC set so triggers fire regularly
        do_arm(2'd2, 32'h0000_0110, 4'd3);
        for (int n = 0; n < 3000; n++) begin
            arm       = $urandom_range(59) == 0;
            stop      = $urandom_range(79) == 0;
            mode      = 2'($urandom_range(3));
            trig_pc   = 32'h100 + 32'(4 * $urandom_range(7));
            post_cnt  = 4'($urandom_range(15));
            in_valid  = $urandom_range(3) != 0;
            in_pc     = 32'h100 + 32'(4 * $urandom_range(7));
            in_inst   = $urandom;
            in_we     = 1'($urandom);
            in_waddr  = 5'($urandom);
            in_wdata  = $urandom;
            out_ready = $urandom_range(2) == 0;
            tick();
        end
        arm = 1'b0;
        stop = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
